// File: rtl/password_sender.sv
// Initiator side of the serial password-lock protocol: shifts a latched code out
// MSB first on enter/inbit strobes, waits for the verdict and retries on reject/timeout.
module password_sender #(
  parameter int CODE_LEN     = 3,
  parameter int GAP          = 1,
  parameter int RESP_TIMEOUT = 4,
  parameter int MAX_ATTEMPTS = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [CODE_LEN-1:0]                   code,
  input  logic                                  unlock,
  input  logic                                  error,
  output logic                                  enter,
  output logic                                  inbit,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  fail,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     attempt
);

  localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW = $clog2(RESP_TIMEOUT);
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);

  localparam logic [IW-1:0] IDX_TOP  = IW'(CODE_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT - 1);
  localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_ATTEMPTS);
  localparam logic [AW-1:0] ATT_ONE  = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_GAP   = 3'd2,
    S_RESP  = 3'd3,
    S_RETRY = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CODE_LEN-1:0]   code_q, code_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [AW-1:0]         att_q, att_d;
  logic                  enter_q, enter_d;
  logic                  inbit_q, inbit_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic                  att_fail_s;

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    att_d      = att_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    att_fail_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          code_d  = code;
          att_d   = ATT_ONE;
          idx_d   = IDX_TOP;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (error) begin
          att_fail_s = 1'b1;
        end else if (idx_q != '0) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          tmo_d   = '0;
          state_d = S_RESP;
        end
      end
      S_GAP: begin
        if (error) begin
          att_fail_s = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          idx_d   = idx_q - IW'(1);
          state_d = S_SEND;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_RESP: begin
        // A reject outranks a simultaneous unlock.
        if (error) begin
          att_fail_s = 1'b1;
        end else if (unlock) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          att_fail_s = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RETRY: begin
        att_d   = att_q + AW'(1);
        idx_d   = IDX_TOP;
        state_d = S_SEND;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (att_fail_s && (att_q == ATT_MAX)) begin
      fail_d  = 1'b1;
      state_d = S_IDLE;
    end else if (att_fail_s) begin
      state_d = S_RETRY;
    end else begin
      fail_d = 1'b0;
    end

    enter_d = (state_d == S_SEND);
    inbit_d = enter_d & code_d[idx_d];
    busy_d  = (state_d != S_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      att_q   <= '0;
      enter_q <= 1'b0;
      inbit_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      att_q   <= att_d;
      enter_q <= enter_d;
      inbit_q <= inbit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign enter   = enter_q;
  assign inbit   = inbit_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign fail    = fail_q;
  assign attempt = att_q;

endmodule

// File: doc/password_sender.md
Name: password_sender

Overview:
- Initiator side of the serial password-lock protocol (enter strobe + inbit, answered by unlock/error pulses).
- Serializes a CODE_LEN-bit code MSB first, one bit per enter strobe, then waits for the lock's verdict.
- Retries automatically on error or timeout, up to MAX_ATTEMPTS total attempts.
- Reports done or fail to the controlling logic (test sequencer or host FSM).

Parameters:
- CODE_LEN, 3: number of code bits sent per attempt (>=1).
- GAP, 1: low cycles of enter between consecutive strobes (>=1).
- RESP_TIMEOUT, 4: cycles after the final strobe in which unlock must arrive (>=2).
- MAX_ATTEMPTS, 3: total attempts before fail (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- code  in  CODE_LEN  code to send; latched on accepted start.
- unlock  in  1  one-cycle success pulse from the lock.
- error  in  1  one-cycle reject pulse from the lock.
- enter  out  1  bit-valid strobe to the lock, registered.
- inbit  out  1  data bit to the lock, registered; valid while enter=1.
- busy  out  1  high from the cycle after accepted start until done/fail is issued.
- done  out  1  one-cycle pulse on successful unlock.
- fail  out  1  one-cycle pulse when all attempts are exhausted.
- attempt  out  $clog2(MAX_ATTEMPTS+1)  current attempt number (1..MAX_ATTEMPTS); holds its last value after done/fail.

Behaviour:
- Reset values: enter=0, inbit=0, busy=0, done=0, fail=0, attempt=0, state=IDLE, code register=0.
- Reset mid-operation: all outputs return to reset values on the cycle after rst is sampled high. No partial strobe is ever extended.
- States: IDLE, SEND, GAP_WAIT, RESP_WAIT, RETRY.
- IDLE:
  - start=1 latches code and sets attempt=1 and bit index=CODE_LEN-1.
  - busy rises next cycle; the first enter strobe is also the next cycle (latency 1).
  - start while busy is ignored.
- SEND:
  - enter=1 for exactly one cycle, with inbit=code_reg[index].
  - If index>0, go to GAP_WAIT. If index=0, go to RESP_WAIT.
- GAP_WAIT:
  - enter=0 for exactly GAP cycles, then decrement index and return to SEND.
- Error during sending:
  - error sampled high in any cycle of SEND or GAP_WAIT ends the attempt at once and goes to RETRY.
  - No further strobes are issued for that attempt.
  - The lock's registered error appears the cycle after the offending strobe, so it always lands in GAP_WAIT or RESP_WAIT.
- RESP_WAIT:
  - Counts RESP_TIMEOUT cycles, starting the cycle after the final strobe.
  - unlock=1 (and error=0): done=1 next cycle, busy=0 in that same cycle, go to IDLE.
  - error=1, including when unlock=1 in the same cycle (error wins): attempt failed.
  - Counter expires with no unlock: attempt failed.
- unlock sampled outside RESP_WAIT is ignored.
- Failed attempt:
  - If attempt<MAX_ATTEMPTS, go to RETRY.
  - If attempt=MAX_ATTEMPTS, fail=1 next cycle, busy=0 in that same cycle, go to IDLE.
- RETRY:
  - One cycle with enter=0; increment attempt, reset index to CODE_LEN-1, go to SEND.
  - The same latched code is resent; the code input is not re-sampled.
- Outputs:
  - done and fail are mutually exclusive and each is high for exactly one cycle per request.
  - enter is never high in two consecutive cycles.
- CODE_LEN=1: SEND goes directly to RESP_WAIT; GAP_WAIT is never entered.
- Counters: gap counter sized for GAP, timeout counter sized for RESP_TIMEOUT; no wrap-around is permitted within a state.

Test Plan:
- Correct code: CODE_LEN=3, GAP=1, code=3'b101, model lock answers 1-0-1 with unlock the cycle after the third strobe.
  -> enter strobes at cycles 1, 3, 5 with inbit 1, 0, 1; done at cycle 7; attempt=1; fail never asserted.
- Wrong code: code=3'b111, lock errors after the second strobe, MAX_ATTEMPTS=3.
  -> each attempt aborts after 2 strobes; attempt steps 1→2→3; fail pulses once; 6 strobes in total; done never asserted.
- Silent lock: code=3'b101, lock never responds, RESP_TIMEOUT=4.
  -> 4 cycles of RESP_WAIT per attempt; 3 full attempts of 3 strobes each; fail pulse.
- Simultaneous unlock and error in RESP_WAIT, MAX_ATTEMPTS=1.
  -> fail=1, done=0.
- Reset asserted on the cycle of the second strobe.
  -> next cycle enter=0, busy=0, attempt=0. A subsequent start restarts cleanly from MSB with attempt=1.
- start pulsed while busy with a different code.
  -> ignored; the original latched code continues; exactly one done/fail per accepted start.
